spi_slave_core: RTL and testbench

Parametrised SPI slave. It supports any word width, all four SPI modes (CPOL/CPHA) and either bit order. The user side has a transmit holding register with a ready/load handshake, a single-cycle receive strobe and an underrun flag. It replaces the fixed 8-bit mode-0 slave between the external SPI pins and the register and command logic. All SPI inputs are oversampled in the system clock domain.

---
 rtl/spi_slave_core.sv | 149 ++++++++++++++
 tb/tb_spi_slave_core.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI slave core: oversampled SPI pins, any word width, all four CPOL/CPHA modes, either bit order.
// The user side has a single-word transmit holding register and a one-cycle receive strobe.
module spi_slave_core #(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ss,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic          SCLK_IDLE = (CPOL != 0);

  // [0],[1] form the synchroniser, [2] is the history stage used for edge detection
  logic [2:0]       sclk_pipe_q, ss_pipe_q, mosi_pipe_q;
  logic [WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             tx_ready_q, tx_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_start, frame_en, do_sample, do_shift, complete, load_point;
  logic [WIDTH-1:0] rx_shifted, tx_shifted;

  assign sclk_rise   = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall   = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign lead_edge   = SCLK_IDLE ? sclk_fall : sclk_rise;
  assign trail_edge  = SCLK_IDLE ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  assign ss_start = ~ss_pipe_q[1] & ss_pipe_q[2];
  // Enabled through the ss_end cycle so a coincident final edge still completes the word
  assign frame_en  = ~ss_pipe_q[2];
  assign do_sample = frame_en & sample_edge;
  assign do_shift  = frame_en & shift_edge;

  assign complete = (CPHA != 0) ? (do_sample && (bit_cnt_q == CNT_LAST))
                                : (do_shift && (bit_cnt_q == CNT_FULL));
  assign load_point = ss_start | (complete & ~ss_pipe_q[1]);

  assign rx_shifted = (MSB_FIRST != 0) ? {shift_rx_q[WIDTH-2:0], mosi_pipe_q[2]}
                                       : {mosi_pipe_q[2], shift_rx_q[WIDTH-1:1]};
  assign tx_shifted = (MSB_FIRST != 0) ? {shift_tx_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shift_tx_q[WIDTH-1:1]};

  always_comb begin
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;

    if (tx_load && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    if (do_sample) begin
      shift_rx_d = rx_shifted;
      bit_cnt_d  = bit_cnt_q + 1'b1;
    end

    // With CPHA=1 bit 0 is already on miso, so the first leading edge of a word holds
    if (do_shift && !complete && ((CPHA == 0) || (bit_cnt_q != '0))) begin
      shift_tx_d = tx_shifted;
    end

    if (complete) begin
      rx_data_d  = do_sample ? rx_shifted : shift_rx_q;
      rx_valid_d = 1'b1;
      bit_cnt_d  = '0;
      shift_rx_d = '0;
    end

    if (load_point) begin
      if (!tx_ready_q) begin
        shift_tx_d = hold_q;
        tx_ready_d = 1'b1;
      end else begin
        shift_tx_d = '0;
        underrun_d = 1'b1;
      end
    end

    if (ss_pipe_q[1]) begin
      bit_cnt_d  = '0;
      shift_rx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sclk_pipe_q <= {3{SCLK_IDLE}};
      ss_pipe_q   <= 3'b111;
      mosi_pipe_q <= 3'b000;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      tx_ready_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_pipe_q <= {sclk_pipe_q[1:0], sclk};
      ss_pipe_q   <= {ss_pipe_q[1:0], ss};
      mosi_pipe_q <= {mosi_pipe_q[1:0], mosi};
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy        = ~ss_pipe_q[1];
  assign miso        = busy & ((MSB_FIRST != 0) ? shift_tx_q[WIDTH-1] : shift_tx_q[0]);
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: four instances covering width, mode and bit-order variants,
// driven by a bit-level SPI master and checked against a word-level holding-register model.
module tb_spi_slave_core;

  localparam int NI = 4;
  localparam int H  = 8;

  function automatic int cfg_w(input int i);    return (i == 1) ? 16 : 8; endfunction
  function automatic int cfg_cpol(input int i); return (i == 1 || i == 3) ? 1 : 0; endfunction
  function automatic int cfg_cpha(input int i); return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int cfg_msb(input int i);  return (i == 1) ? 0 : 1; endfunction
  function automatic logic [15:0] wmask(input int w); return (w == 16) ? 16'hFFFF : 16'h00FF; endfunction

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  logic        sclk_w[NI], ss_w[NI], mosi_w[NI], miso_w[NI];
  logic        tx_load_w[NI], tx_ready_w[NI], rx_valid_w[NI], tx_underrun_w[NI], busy_w[NI];
  logic [15:0] tx_data_w[NI], rx_data_w[NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = cfg_w(gi);
    spi_slave_core #(
      .WIDTH(W), .CPOL(cfg_cpol(gi)), .CPHA(cfg_cpha(gi)), .MSB_FIRST(cfg_msb(gi))
    ) u_dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .sclk       (sclk_w[gi]),
      .mosi       (mosi_w[gi]),
      .ss         (ss_w[gi]),
      .miso       (miso_w[gi]),
      .tx_data    (tx_data_w[gi][W-1:0]),
      .tx_load    (tx_load_w[gi]),
      .tx_ready   (tx_ready_w[gi]),
      .rx_data    (rx_data_w[gi][W-1:0]),
      .rx_valid   (rx_valid_w[gi]),
      .tx_underrun(tx_underrun_w[gi]),
      .busy       (busy_w[gi])
    );
    if (W < 16) begin : g_pad
      assign rx_data_w[gi][15:W] = '0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse monitor: logs received words, counts underruns and flags pulses wider than one cycle
  int          rx_cnt[NI];
  int          ur_cnt[NI];
  int          wide_cnt[NI];
  bit          prev_rv[NI];
  bit          prev_ur[NI];
  logic [15:0] rx_log[NI][64];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rx_valid_w[i] === 1'b1) begin
        rx_log[i][rx_cnt[i] % 64] <= rx_data_w[i];
        rx_cnt[i] <= rx_cnt[i] + 1;
      end
      if (tx_underrun_w[i] === 1'b1) ur_cnt[i] <= ur_cnt[i] + 1;
      if ((rx_valid_w[i] === 1'b1 && prev_rv[i]) || (tx_underrun_w[i] === 1'b1 && prev_ur[i]))
        wide_cnt[i] <= wide_cnt[i] + 1;
      prev_rv[i] <= (rx_valid_w[i] === 1'b1);
      prev_ur[i] <= (tx_underrun_w[i] === 1'b1);
    end
  end

  // Word-level reference model
  bit          m_full[NI];
  logic [15:0] m_hold[NI];
  int          m_under[NI];
  logic [15:0] m_rx[NI];

  // Per-frame stimulus tables
  logic [15:0] f_mosi[4];
  bit          f_load[4];
  logic [15:0] f_lval[4];

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_load(input int i, output logic [15:0] w);
    if (m_full[i]) begin
      w = m_hold[i];
      m_full[i] = 1'b0;
    end else begin
      w = '0;
      m_under[i]++;
    end
  endtask

  task automatic user_load(input int i, input logic [15:0] v);
    tx_data_w[i] = v;
    tx_load_w[i] = 1'b1;
    wait_cyc(1);
    tx_load_w[i] = 1'b0;
    m_hold[i] = v & wmask(cfg_w(i));
    m_full[i] = 1'b1;
  endtask

  function automatic logic bitn(input logic [15:0] w, input int width, input int msb, input int b);
    logic [15:0] t;
    t = w;
    return t[(msb != 0) ? (width - 1 - b) : b];
  endfunction

  task automatic run_frame(input int i, input int nwords, input int abort_bits);
    int          w, cpol, cpha, msb, pos, rx_base, nexp;
    bit          aborted;
    logic [15:0] exp_tx, got;
    w = cfg_w(i); cpol = cfg_cpol(i); cpha = cfg_cpha(i); msb = cfg_msb(i);
    aborted = 1'b0;
    model_load(i, exp_tx);
    rx_base = rx_cnt[i];
    ss_w[i] = 1'b0;
    if (cpha == 0) mosi_w[i] = bitn(f_mosi[0], w, msb, 0);
    wait_cyc(H);
    check_eq("busy_active", busy_w[i], 1);
    for (int k = 0; k < nwords && !aborted; k++) begin
      got = '0;
      for (int b = 0; b < w; b++) begin
        if (abort_bits > 0 && b == abort_bits) begin
          aborted = 1'b1;
          break;
        end
        if (b == 2 && f_load[k] && !m_full[i]) user_load(i, f_lval[k]);
        pos = (msb != 0) ? (w - 1 - b) : b;
        if (cpha == 0) begin
          got[pos] = miso_w[i];
          sclk_w[i] = (cpol == 0);
          wait_cyc(H);
          sclk_w[i] = (cpol != 0);
          if (b < w - 1) mosi_w[i] = bitn(f_mosi[k], w, msb, b + 1);
          else if (k + 1 < nwords) mosi_w[i] = bitn(f_mosi[k + 1], w, msb, 0);
          wait_cyc(H);
        end else begin
          sclk_w[i] = (cpol == 0);
          mosi_w[i] = bitn(f_mosi[k], w, msb, b);
          wait_cyc(H);
          got[pos] = miso_w[i];
          sclk_w[i] = (cpol != 0);
          wait_cyc(H);
        end
      end
      if (!aborted) begin
        check_eq("miso_word", got, exp_tx);
        m_rx[i] = f_mosi[k];
        model_load(i, exp_tx);
      end
    end
    ss_w[i] = 1'b1;
    wait_cyc(H);
    nexp = aborted ? 0 : nwords;
    check_eq("rx_valid_count", rx_cnt[i] - rx_base, nexp);
    for (int k = 0; k < nexp; k++) check_eq("rx_word", rx_log[i][(rx_base + k) % 64], f_mosi[k]);
    check_eq("rx_data_hold", rx_data_w[i], m_rx[i]);
    check_eq("underrun_count", ur_cnt[i], m_under[i]);
    check_eq("tx_ready", tx_ready_w[i], !m_full[i]);
    check_eq("busy_idle", busy_w[i], 0);
    check_eq("miso_idle", miso_w[i], 0);
    check_eq("pulse_width", wide_cnt[i], 0);
    $display("[TB] inst %0d frame: words=%0d abort_bits=%0d rx_data=0x%0h underruns=%0d",
             i, nwords, abort_bits, rx_data_w[i], ur_cnt[i]);
    wait_cyc(3);
  endtask

  task automatic check_reset_outputs(input int i);
    check_eq("rst_miso", miso_w[i], 0);
    check_eq("rst_rx_data", rx_data_w[i], 0);
    check_eq("rst_rx_valid", rx_valid_w[i], 0);
    check_eq("rst_tx_ready", tx_ready_w[i], 1);
    check_eq("rst_underrun", tx_underrun_w[i], 0);
    check_eq("rst_busy", busy_w[i], 0);
  endtask

  // Mode-0 instance 0: reset asserted while bit 4 is in flight with the holding register full
  task automatic reset_mid_word();
    logic [15:0] tmp;
    if (!m_full[0]) user_load(0, 16'h004D);
    model_load(0, tmp);
    ss_w[0] = 1'b0;
    mosi_w[0] = 1'b1;
    wait_cyc(H);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) user_load(0, 16'h00E7);
      sclk_w[0] = 1'b1;
      wait_cyc(H);
      sclk_w[0] = 1'b0;
      mosi_w[0] = b[0];
      wait_cyc(H);
    end
    sclk_w[0] = 1'b1;
    wait_cyc(2);
    n_reset = 1'b0;
    #2;
    check_reset_outputs(0);
    sclk_w[0] = 1'b0;
    ss_w[0]   = 1'b1;
    wait_cyc(3);
    check_reset_outputs(0);
    n_reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      m_full[i] = 1'b0;
      m_rx[i]   = '0;
    end
    wait_cyc(4);
    $display("[TB] inst 0 reset mid-word: tx_ready=%0b busy=%0b", tx_ready_w[0], busy_w[0]);
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 4; k++) begin
      f_mosi[k] = '0; f_load[k] = 1'b0; f_lval[k] = '0;
    end
  endtask

  initial begin
    n_reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      sclk_w[i] = (cfg_cpol(i) != 0);
      ss_w[i] = 1'b1; mosi_w[i] = 1'b0; tx_load_w[i] = 1'b0; tx_data_w[i] = '0;
      m_full[i] = 1'b0; m_hold[i] = '0; m_under[i] = 0; m_rx[i] = '0;
    end
    wait_cyc(3);
    for (int i = 0; i < NI; i++) check_reset_outputs(i);
    n_reset = 1'b1;
    wait_cyc(4);

    // Mode 0, 8-bit MSB first
    clear_frame(); f_mosi[0] = 16'h003C;
    user_load(0, 16'h00A5);
    run_frame(0, 1, 0);
    check_eq("s1_rx_data", rx_data_w[0], 16'h003C);

    // Mode 3, 16-bit LSB first
    clear_frame(); f_mosi[0] = 16'h1234;
    user_load(1, 16'h8001);
    run_frame(1, 1, 0);

    // Mode 1, two back-to-back words with a reload during the first
    clear_frame(); f_mosi[0] = 16'h00FF; f_mosi[1] = 16'h0000;
    f_load[0] = 1'b1; f_lval[0] = 16'h00C3;
    user_load(2, 16'h005A);
    run_frame(2, 2, 0);

    // Mode 2 with nothing loaded: underrun, miso all zero
    clear_frame(); f_mosi[0] = 16'h006B;
    run_frame(3, 1, 0);

    // Abort after 5 bits; the reload made during the aborted word must survive
    clear_frame(); f_mosi[0] = 16'h00F0; f_load[0] = 1'b1; f_lval[0] = 16'h0077;
    user_load(0, 16'h0011);
    run_frame(0, 1, 5);
    clear_frame(); f_mosi[0] = 16'h0096;
    run_frame(0, 1, 0);

    // Reset mid-word, then the first scenario again
    reset_mid_word();
    clear_frame(); f_mosi[0] = 16'h003C;
    user_load(0, 16'h00A5);
    run_frame(0, 1, 0);

    // Randomised frames across all instances
    for (int r = 0; r < 24; r++) begin
      int i, nw, ab;
      i  = $urandom_range(0, NI - 1);
      nw = $urandom_range(1, 3);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, cfg_w(i) - 1) : 0;
      if (ab != 0) nw = 1;
      clear_frame();
      for (int k = 0; k < nw; k++) begin
        f_mosi[k] = 16'($urandom) & wmask(cfg_w(i));
        f_load[k] = 1'($urandom_range(0, 1));
        f_lval[k] = 16'($urandom) & wmask(cfg_w(i));
      end
      if (!m_full[i] && $urandom_range(0, 1) == 1) user_load(i, 16'($urandom) & wmask(cfg_w(i)));
      run_frame(i, nw, ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
